clock_divider_prog: RTL and testbench

Runtime-programmable, multi-channel successor to the fixed-parameter clock divider. Each of NUM_CH channels divides the system clock by its own divisor, which is loaded through a write port and applied glitch-free at that channel's next period boundary. Each channel drives a registered divided-clock level and a one-cycle period tick usable as a clock enable. Sits beside the system clock source and feeds slow-rate logic (baud generators, LED/scan timers).

---
 rtl/clock_divider_prog.sv | 109 ++++++++++
 tb/tb_clock_divider_prog.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Runtime-programmable multi-channel clock divider with glitch-free divisor updates at period boundaries.
// Optional global phase realign via sync_in when CLKDIV_SYNC_EN is defined.
module clock_divider_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);

  // Number of low cycles in a period: ceil(n/2), computed without overflow at n = 2^DIV_W-1.
  function automatic logic [DIV_W-1:0] low_len(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] s;
    s = {1'b0, n} + (DIV_W+1)'(1);
    return s[DIV_W:1];
  endfunction

  logic sync_hit;
`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  logic sync_unused;
  assign sync_unused = sync_in;
  assign sync_hit    = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_sel;
    logic             last;

    // Out-of-range channel numbers match no channel and are dropped here.
    assign wr_sel = wr_en && (wr_ch == CH_W'(i));
    // A halted channel (div 0) sits on a boundary every cycle so a pending divisor applies at once.
    assign last   = (div_q == '0) || (cnt_q == div_q - ONE);

    always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      if (sync_hit) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else if (last) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // A write landing on a boundary becomes the next pending value, after the old one applies.
      if (wr_sel) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end
      clk_d  = !sync_hit && (div_d != '0) && (cnt_d >= low_len(div_d));
      tick_d = !sync_hit && (div_d != '0) && (cnt_d == div_d - ONE);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        div_q  <= RST_DIV;
        cnt_q  <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    // Pending divisor is only meaningful while pend_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
      pdiv_q <= pdiv_d;
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog: table-driven reset/odd-divisor vectors plus corner-case sequences.
// The realign sequence is compiled only when CLKDIV_SYNC_EN is defined.
module tb_clock_divider_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_en1 = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [15:0] wr_div = 16'd0;
  logic        sync_in = 1'b0;
  logic [3:0]  clk_out, tick, pending;
  logic [2:0]  clk_out1, tick1, pending1;

  int checks = 0;
  int errors = 0;

  clock_divider_prog #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .sync_in(sync_in), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  clock_divider_prog #(.NUM_CH(3), .DIV_W(16), .DEFAULT_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_ch(wr_ch), .wr_div(wr_div),
    .sync_in(sync_in), .clk_out(clk_out1), .tick(tick1), .pending(pending1)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [3:0]  e_clk;
    logic [3:0]  e_tick;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic [1:0] ch, input logic [15:0] div);
    wr_en  = we;
    wr_ch  = ch;
    wr_div = div;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic exp_clk(input int n, input int k);
    return (n >= 2) && (k >= (n + 1) / 2);
  endfunction

  function automatic logic exp_tick(input int n, input int k);
    return (n >= 1) && (k == n - 1);
  endfunction

  task automatic wait_apply(input int ch);
    int n = 0;
    while (pending[ch] && n < 100) begin
      cycle(1'b0, 2'd0, 16'd0);
      n++;
    end
    chk($sformatf("apply_ch%0d", ch), 32'(pending[ch]), 32'd0);
  endtask

  task automatic check_period(input int ch, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_clk_k%0d", name, k), 32'(clk_out[ch]), 32'(exp_clk(n, k)));
      chk($sformatf("%s_tick_k%0d", name, k), 32'(tick[ch]), 32'(exp_tick(n, k)));
      cycle(1'b0, 2'd0, 16'd0);
    end
  endtask

  initial begin
    // rst, we, ch, div, clk_out, tick, pending (bit i = channel i)
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b1111, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b1111, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 16'd5, 4'b0000, 4'b0000, 4'b0010};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b1111, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1101, 4'b1101, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b1101, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010, 4'b0000};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1101, 4'b1101, 4'b0000};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 16'd9, 4'b0000, 4'b0000, 4'b0001};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b1111, 4'b0000};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      cycle(vecs[i].we, vecs[i].ch, vecs[i].div);
      chk($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(vecs[i].e_clk));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].e_pend));
    end

    // Mid-period write on ch2 (N=10): write 4 at cnt=3, overwrite with 7 at cnt=6.
    do_reset();
    cycle(1'b1, 2'd2, 16'd10);
    wait_apply(2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("mid_clk_k%0d", k), 32'(clk_out[2]), 32'(exp_clk(10, k)));
      chk($sformatf("mid_tick_k%0d", k), 32'(tick[2]), 32'(exp_tick(10, k)));
      if (k == 4 || k == 9) chk($sformatf("mid_pend_k%0d", k), 32'(pending[2]), 32'd1);
      if (k == 3)      cycle(1'b1, 2'd2, 16'd4);
      else if (k == 6) cycle(1'b1, 2'd2, 16'd7);
      else             cycle(1'b0, 2'd0, 16'd0);
    end
    chk("mid_pend_cleared", 32'(pending[2]), 32'd0);
    check_period(2, 7, "mid_p7a");
    check_period(2, 7, "mid_p7b");

    // Halt ch3, then resume with N=3 one cycle after the write.
    do_reset();
    cycle(1'b1, 2'd3, 16'd0);
    wait_apply(3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt_clk_k%0d", k), 32'(clk_out[3]), 32'd0);
      chk($sformatf("halt_tick_k%0d", k), 32'(tick[3]), 32'd0);
      cycle(1'b0, 2'd0, 16'd0);
    end
    cycle(1'b1, 2'd3, 16'd3);
    chk("resume_pend", 32'(pending[3]), 32'd1);
    chk("resume_wait_clk", 32'(clk_out[3]), 32'd0);
    chk("resume_wait_tick", 32'(tick[3]), 32'd0);
    cycle(1'b0, 2'd0, 16'd0);
    chk("resume_pend_cleared", 32'(pending[3]), 32'd0);
    check_period(3, 3, "resume_a");
    check_period(3, 3, "resume_b");

    // N=1 on ch0, then write-on-boundary: old pending (4) applies, new (2) waits.
    do_reset();
    cycle(1'b1, 2'd0, 16'd1);
    wait_apply(0);
    check_period(0, 1, "n1_a");
    check_period(0, 1, "n1_b");
    check_period(0, 1, "n1_c");
    cycle(1'b1, 2'd0, 16'd4);
    chk("wb_pend_first", 32'(pending[0]), 32'd1);
    chk("wb_tick_first", 32'(tick[0]), 32'd1);
    cycle(1'b1, 2'd0, 16'd2);
    chk("wb_pend_second", 32'(pending[0]), 32'd1);
    check_period(0, 4, "wb_p4");
    chk("wb_pend_cleared", 32'(pending[0]), 32'd0);
    check_period(0, 2, "wb_p2");

    // Out-of-range channel on a 3-channel instance must leave it untouched.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("oor_clk_k%0d", k), 32'(clk_out1), 32'({3{exp_clk(3, k % 3)}}));
      chk($sformatf("oor_tick_k%0d", k), 32'(tick1), 32'({3{exp_tick(3, k % 3)}}));
      chk($sformatf("oor_pend_k%0d", k), 32'(pending1), 32'd0);
      wr_en1 = (k == 0 || k == 2);
      cycle(1'b0, 2'd3, 16'd7);
      wr_en1 = 1'b0;
    end

`ifdef CLKDIV_SYNC_EN
    // Realign: ch0=4, ch1=6 restart together and tick together every 12 cycles.
    do_reset();
    cycle(1'b1, 2'd0, 16'd4);
    cycle(1'b1, 2'd1, 16'd6);
    wait_apply(0);
    wait_apply(1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 16'd0);
    sync_in = 1'b1;
    cycle(1'b1, 2'd2, 16'd5);
    sync_in = 1'b0;
    chk("sync_clk_out", 32'(clk_out), 32'd0);
    chk("sync_tick", 32'(tick), 32'd0);
    chk("sync_wr_pending", 32'(pending), 32'b0100);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("sync_c0_clk_k%0d", k), 32'(clk_out[0]), 32'(exp_clk(4, k % 4)));
      chk($sformatf("sync_c0_tick_k%0d", k), 32'(tick[0]), 32'(exp_tick(4, k % 4)));
      chk($sformatf("sync_c1_clk_k%0d", k), 32'(clk_out[1]), 32'(exp_clk(6, k % 6)));
      chk($sformatf("sync_c1_tick_k%0d", k), 32'(tick[1]), 32'(exp_tick(6, k % 6)));
      cycle(1'b0, 2'd0, 16'd0);
    end
    cycle(1'b1, 2'd3, 16'd9);
    sync_in = 1'b1;
    cycle(1'b0, 2'd0, 16'd0);
    sync_in = 1'b0;
    chk("sync_apply_pend", 32'(pending[3]), 32'd0);
    check_period(3, 9, "sync_p9");
    rst = 1'b1;
    sync_in = 1'b1;
    cycle(1'b1, 2'd0, 16'd8);
    sync_in = 1'b0;
    rst = 1'b0;
    chk("rst_sync_clk", 32'(clk_out), 32'd0);
    chk("rst_sync_tick", 32'(tick), 32'd0);
    chk("rst_sync_pend", 32'(pending), 32'd0);
    cycle(1'b0, 2'd0, 16'd0);
    chk("rst_sync_after_clk", 32'(clk_out), 32'b1111);
    chk("rst_sync_after_tick", 32'(tick), 32'b1111);
`endif

    // Maximum divisor on ch1: first tick lands 65534 cycles after the apply.
    do_reset();
    cycle(1'b1, 2'd1, 16'd65535);
    wait_apply(1);
    begin
      int n = 0;
      while (!tick[1] && n < 70000) begin
        cycle(1'b0, 2'd0, 16'd0);
        n++;
      end
      chk("max_div_tick_pos", 32'(n), 32'd65534);
      chk("max_div_clk_high", 32'(clk_out[1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
